// File: rtl/sum_serial_nb_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e    : FSM state encoding (idle / run / done)
//   clog2_min1 : ceil(log2(n)) with a floor of 1, used to size the digit counter
package sum_serial_nb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter width for n digits; never less than one bit so NDIG=1 still elaborates.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_nb.sv
// N-bit combinational ripple-carry adder: S = A + B + Ci, Co = carry out of bit N-1.
// Ports:
//   A, B  in  N   addends
//   Ci    in  1   carry-in to bit 0
//   S     out N   sum
//   Co    out 1   carry-out
module sum_nb #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    output logic [N-1:0] S,
    output logic         Co
);

    logic [N:0] c;

    assign c[0] = Ci;

    // One full-adder cell per bit, carry chained from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Co = c[N];

endmodule

// File: rtl/sum_serial_nb.sv
// Digit-serial adder/subtractor. A WIDTH-bit operation is processed DIGIT bits per
// clock, least-significant digit first, through one DIGIT-bit ripple adder.
// Subtraction is done as A + ~B + ~Ci.
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, accepted in idle or done
//   sub    in  1      0: S = A+B+Ci, 1: S = A-B-Ci
//   A, B   in  WIDTH  operands, captured on accepted start
//   Ci     in  1      carry-in / borrow-in, captured on accepted start
//   busy   out 1      operation in progress
//   done   out 1      one-cycle pulse, S/Co/V valid from this cycle
//   S      out WIDTH  registered result, held until the next final digit
//   Co     out 1      add: carry-out; sub: 1 = no borrow
//   V      out 1      two's-complement overflow
module sum_serial_nb
    import sum_serial_nb_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CNTW = clog2_min1(NDIG);
    localparam logic [CNTW-1:0] LastDig = CNTW'(NDIG - 1);

    state_e           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             carry_q;
    logic             a_msb_q;
    logic             bx_msb_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             v_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic [WIDTH-1:0] part_next;
    logic [WIDTH-1:0] b_cap;
    logic             v_next;

    sum_nb #(
        .N (DIGIT)
    ) u_slice (
        .A  (a_sh_q[DIGIT-1:0]),
        .B  (b_sh_q[DIGIT-1:0]),
        .Ci (carry_q),
        .S  (dig_s),
        .Co (dig_co)
    );

    // New digit enters at the MSB end; after NDIG digits the LSB digit has reached bit 0.
    // Written as a truncated shift so the NDIG=1 case needs no special slice.
    assign part_next = WIDTH'({dig_s, part_q} >> DIGIT);

    assign b_cap = sub ? ~B : B;

    // Same-sign operands producing an opposite-sign result.
    assign v_next = (a_msb_q == bx_msb_q) && (part_next[WIDTH-1] != a_msb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            bx_msb_q <= 1'b0;
            part_q   <= '0;
            s_q      <= '0;
            co_q     <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_sh_q   <= A;
                        b_sh_q   <= b_cap;
                        carry_q  <= sub ? ~Ci : Ci;
                        a_msb_q  <= A[WIDTH-1];
                        bx_msb_q <= b_cap[WIDTH-1];
                        cnt_q    <= '0;
                        state_q  <= StRun;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end else begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end
                end
                StRun: begin
                    a_sh_q  <= a_sh_q >> DIGIT;
                    b_sh_q  <= b_sh_q >> DIGIT;
                    carry_q <= dig_co;
                    part_q  <= part_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastDig) begin
                        s_q     <= part_next;
                        co_q    <= dig_co;
                        v_q     <= v_next;
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Co   = co_q;
    assign V    = v_q;

endmodule

// File: tb/tb_sum_serial_nb.sv
module tb_sum_serial_nb;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned ND = W / D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance, 16/4
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         ci = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         dut_busy, dut_done, dut_co, dut_v;
    logic [W-1:0] dut_s;

    sum_serial_nb #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (a),
        .B     (b),
        .Ci    (ci),
        .busy  (dut_busy),
        .done  (dut_done),
        .S     (dut_s),
        .Co    (dut_co),
        .V     (dut_v)
    );

    // Variant instance, 8/8 (single digit)
    logic       v_start = 1'b0;
    logic       v_sub = 1'b0;
    logic       v_ci = 1'b0;
    logic [7:0] v_a = '0;
    logic [7:0] v_b = '0;
    logic       v_busy, v_done, v_co, v_v;
    logic [7:0] v_s;

    sum_serial_nb #(
        .WIDTH (8),
        .DIGIT (8)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (v_start),
        .sub   (v_sub),
        .A     (v_a),
        .B     (v_b),
        .Ci    (v_ci),
        .busy  (v_busy),
        .done  (v_done),
        .S     (v_s),
        .Co    (v_co),
        .V     (v_v)
    );

    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    logic [W-1:0] exp_s = '0;
    logic         exp_co = 1'b0;
    logic         exp_v = 1'b0;
    logic [7:0]   v_exp_s = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on the operands. Returns {V, Co, S}.
    function automatic logic [33:0] model(input int w, input bit sb, input logic [31:0] ua,
                                          input logic [31:0] ub, input bit c);
        longint m, x, y, sx, sy, full, sv;
        logic [31:0] rs;
        bit rco, rv;
        m  = longint'(1) << w;
        x  = longint'(ua);
        y  = longint'(ub);
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        if (!sb) begin
            full = x + y + longint'(c);
            rco  = (full >= m);
            sv   = sx + sy + longint'(c);
        end else begin
            full = x - y - longint'(c);
            rco  = (full >= 0);
            sv   = sx - sy - longint'(c);
        end
        rs = 32'(((full % m) + m) % m);
        rv = (sv > m / 2 - 1) || (sv < -(m / 2));
        return {rv, rco, rs};
    endfunction

    // Launch one operation from idle/done, optionally pulsing start mid-run, and
    // return at the cycle done is observed.
    task automatic do_op(input bit sb, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit cv, input bit poke);
        logic [33:0] r;
        int cyc;
        r = model(W, sb, 32'(av), 32'(bv), cv);
        sub = sb; a = av; b = bv; ci = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        check_eq("busy_after_start", 32'(dut_busy), 32'd1);
        check_eq("done_after_start", 32'(dut_done), 32'd0);
        check_eq("s_hold_in_run", 32'(dut_s), 32'(exp_s));
        for (cyc = 1; cyc <= 3 * int'(ND); cyc++) begin
            @(posedge clk); #1;
            if (dut_done) break;
            check_eq("busy_in_run", 32'(dut_busy), 32'd1);
            if (poke && cyc == 1) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("latency", 32'(cyc), 32'(ND));
        check_eq("busy_at_done", 32'(dut_busy), 32'd0);
        check_eq("result_s", 32'(dut_s), 32'(r[W-1:0]));
        check_eq("result_co", 32'(dut_co), 32'(r[32]));
        check_eq("result_v", 32'(dut_v), 32'(r[33]));
        exp_s = r[W-1:0]; exp_co = r[32]; exp_v = r[33];
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check_eq("done_pulse_end", 32'(dut_done), 32'd0);
        check_eq("busy_idle", 32'(dut_busy), 32'd0);
        check_eq("s_hold_idle", 32'(dut_s), 32'(exp_s));
        check_eq("co_hold_idle", 32'(dut_co), 32'(exp_co));
    endtask

    task automatic v_do_op(input bit sb, input logic [7:0] av, input logic [7:0] bv,
                           input bit cv);
        logic [33:0] r;
        int cyc;
        r = model(8, sb, 32'(av), 32'(bv), cv);
        v_sub = sb; v_a = av; v_b = bv; v_ci = cv; v_start = 1'b1;
        @(posedge clk); #1;
        v_start = 1'b0; v_a = 8'($urandom); v_b = 8'($urandom);
        check_eq("v_busy_after_start", 32'(v_busy), 32'd1);
        check_eq("v_s_hold", 32'(v_s), 32'(v_exp_s));
        for (cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk); #1;
            if (v_done) break;
        end
        check_eq("v_latency", 32'(cyc), 32'd1);
        check_eq("v_result_s", 32'(v_s), 32'(r[7:0]));
        check_eq("v_result_co", 32'(v_co), 32'(r[32]));
        check_eq("v_result_v", 32'(v_v), 32'(r[33]));
        v_exp_s = r[7:0];
        @(posedge clk); #1;
        check_eq("v_done_end", 32'(v_done), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        check_eq("rst_s", 32'(dut_s), 32'd0);
        check_eq("rst_busy", 32'(dut_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("quiet_s", 32'(dut_s), 32'd0);
            check_eq("quiet_co", 32'(dut_co), 32'd0);
            check_eq("quiet_v", 32'(dut_v), 32'd0);
            check_eq("quiet_busy", 32'(dut_busy), 32'd0);
            check_eq("quiet_done", 32'(dut_done), 32'd0);
        end

        // Directed cases
        do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0); idle_cycle();
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0); idle_cycle();
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        // Back-to-back: start asserted in the done cycle
        do_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0); idle_cycle();
        do_op(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0); idle_cycle();
        do_op(1'b1, 16'h0005, 16'h0004, 1'b1, 1'b0); idle_cycle();
        // Start pulsed mid-run is ignored
        do_op(1'b0, 16'hA5A5, 16'h1111, 1'b1, 1'b1); idle_cycle();

        // Reset during run: abandoned, no done pulse
        sub = 1'b0; a = 16'h4321; b = 16'h1111; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_run_s", 32'(dut_s), 32'd0);
        check_eq("rst_run_co", 32'(dut_co), 32'd0);
        check_eq("rst_run_v", 32'(dut_v), 32'd0);
        check_eq("rst_run_busy", 32'(dut_busy), 32'd0);
        exp_s = '0; exp_co = 1'b0; exp_v = 1'b0; v_exp_s = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("rst_run_no_done", 32'(dut_done), 32'd0);
        end

        // Randomized operations, with random back-to-back starts
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) idle_cycle();
        end
        idle_cycle();

        // Single-digit variant
        v_do_op(1'b0, 8'h7F, 8'h01, 1'b1);
        v_do_op(1'b1, 8'h80, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            v_do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
